// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a whole-word debouncer: the synchronized word must
// hold steady for DEBOUNCE_CYCLES cycles before it is committed to device_values.
module input_debouncer #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             ack,
    output logic [WIDTH-1:0] device_values,
    output logic             changed,
    output logic             stable
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [7:0]       cnt;
    logic             cand_match;
    logic             cnt_done;
    logic             commit;

    assign cand_match = (sync2 == cand);
    assign cnt_done   = (cnt == CNT_LAST);
    assign commit     = cand_match && cnt_done && (cand != device_values);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // Any disagreement with the candidate restarts the count; agreement counts up and saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand <= '0;
            cnt  <= '0;
        end else if (!cand_match) begin
            cand <= sync2;
            cnt  <= '0;
        end else if (cnt < CNT_LAST) begin
            cnt <= cnt + 8'd1;
        end
    end

    // A commit setting changed takes priority over a same-edge ack clearing it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            device_values <= '0;
            changed       <= 1'b0;
        end else if (commit) begin
            device_values <= cand;
            changed       <= 1'b1;
        end else if (ack) begin
            changed <= 1'b0;
        end
    end

    assign stable = (sync2 == device_values) && cnt_done && cand_match;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: a history-window model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_input_debouncer;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] raw_in;
    logic         ack;
    logic [W-1:0] device_values;
    logic         changed;
    logic         stable;

    int n_compared   = 0;
    int n_mismatched = 0;

    input_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .raw_in        (raw_in),
        .ack           (ack),
        .device_values (device_values),
        .changed       (changed),
        .stable        (stable)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the synchronized word is raw_in delayed two edges; a commit happens when the
    // last D+1 pre-edge synchronized words are identical and differ from the committed word.
    logic [W-1:0] m_s1, m_s2, m_dev;
    logic         m_changed;
    logic         m_stable;
    logic [W-1:0] m_hist[$];
    logic [W-1:0] smp_raw;
    logic         smp_ack;
    logic         smp_rst = 1'b0;

    always @(posedge clk) begin
        smp_raw <= raw_in;
        smp_ack <= ack;
        smp_rst <= reset_n;
    end

    function automatic logic windowEqual(input int n, input logic [W-1:0] v);
        if (m_hist.size() < n) return 1'b0;
        for (int i = m_hist.size() - n; i < m_hist.size(); i++)
            if (m_hist[i] !== v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelReset();
        m_s1 = '0;
        m_s2 = '0;
        m_dev = '0;
        m_changed = 1'b0;
        m_hist.delete();
        m_hist.push_back('0);
    endtask

    task automatic modelStep(input logic [W-1:0] r, input logic a);
        logic [W-1:0] pre;
        pre = m_s2;
        m_hist.push_back(pre);
        if (m_hist.size() > D + 1) void'(m_hist.pop_front());
        if (windowEqual(D + 1, pre) && pre != m_dev) begin
            m_dev = pre;
            m_changed = 1'b1;
        end else if (a) begin
            m_changed = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = r;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n || !smp_rst) modelReset();
            else modelStep(smp_raw, smp_ack);
            m_stable = (m_s2 == m_dev) && windowEqual(D, m_s2);
            checkOutput("cyc_device_values", device_values, m_dev);
            checkOutput("cyc_changed", {31'b0, changed}, {31'b0, m_changed});
            checkOutput("cyc_stable", {31'b0, stable}, {31'b0, m_stable});
        end
    end

    task automatic applyStimulus(input logic [W-1:0] r, input logic a);
        raw_in = r;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic pinModel(input logic [W-1:0] exp_dev, input logic exp_changed);
        @(negedge clk);
        #1;
        checkOutput("model_dev", m_dev, exp_dev);
        checkOutput("model_changed", {31'b0, m_changed}, {31'b0, exp_changed});
    endtask

    initial begin
        reset_n = 1'b0;
        raw_in  = '0;
        ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_device_values", device_values, 32'h0);
        checkOutput("reset_changed", {31'b0, changed}, 32'h0);
        checkOutput("reset_stable", {31'b0, stable}, 32'h0);

        // Latency: first sampling edge is j=0, commit lands on j=6.
        reset_n = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            applyStimulus(32'hE5F84AB1, 1'b0);
            checkOutput("latency_device_values", device_values, (j == 6) ? 32'hE5F84AB1 : 32'h0);
        end
        checkOutput("latency_changed", {31'b0, changed}, 32'h1);
        checkOutput("latency_stable", {31'b0, stable}, 32'h1);
        pinModel(32'hE5F84AB1, 1'b1);

        applyStimulus(32'hE5F84AB1, 1'b1);
        checkOutput("ack_changed", {31'b0, changed}, 32'h0);
        checkOutput("ack_device_values", device_values, 32'hE5F84AB1);
        applyStimulus(32'hE5F84AB1, 1'b1);
        checkOutput("ack_repeat_changed", {31'b0, changed}, 32'h0);
        checkOutput("ack_repeat_device_values", device_values, 32'hE5F84AB1);

        for (int h = 0; h < 8; h++) applyStimulus(32'h0, 1'b0);
        checkOutput("zero_commit_device_values", device_values, 32'h0);
        checkOutput("zero_commit_changed", {31'b0, changed}, 32'h1);
        applyStimulus(32'h0, 1'b1);

        // A 3-cycle pulse is too short to commit.
        for (int g = 0; g < 11; g++) begin
            applyStimulus((g < 3) ? 32'h1 : 32'h0, 1'b0);
            checkOutput("glitch_device_values", device_values, 32'h0);
            checkOutput("glitch_changed", {31'b0, changed}, 32'h0);
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? 32'h1 : 32'h0, 1'b0);
            checkOutput("bounce_device_values", device_values, 32'h0);
        end
        for (int h = 0; h < 8; h++) begin
            applyStimulus(32'h1, 1'b0);
            checkOutput("bounce_hold_device_values", device_values, (h >= 6) ? 32'h1 : 32'h0);
            checkOutput("bounce_hold_changed", {31'b0, changed}, (h >= 6) ? 32'h1 : 32'h0);
        end
        pinModel(32'h1, 1'b1);

        applyStimulus(32'h1, 1'b1);
        checkOutput("pre_simul_changed", {31'b0, changed}, 32'h0);
        for (int h = 0; h <= 6; h++) applyStimulus(32'h5C8C6A01, (h == 6));
        checkOutput("simul_changed", {31'b0, changed}, 32'h1);
        checkOutput("simul_device_values", device_values, 32'h5C8C6A01);
        applyStimulus(32'h5C8C6A01, 1'b1);
        checkOutput("simul_ack_changed", {31'b0, changed}, 32'h0);

        for (int h = 0; h <= 6; h++) applyStimulus(32'hA5A5A5A5, 1'b0);
        checkOutput("first_commit_device_values", device_values, 32'hA5A5A5A5);
        for (int h = 0; h <= 6; h++) applyStimulus(32'h0F0F0F0F, 1'b0);
        checkOutput("overwrite_device_values", device_values, 32'h0F0F0F0F);
        checkOutput("overwrite_changed", {31'b0, changed}, 32'h1);
        pinModel(32'h0F0F0F0F, 1'b1);

        // Brief excursion back to the committed word must not re-commit it.
        applyStimulus(32'h0F0F0F0F, 1'b1);
        for (int h = 0; h < 12; h++) applyStimulus((h < 2) ? 32'h0 : 32'h0F0F0F0F, 1'b0);
        checkOutput("same_value_changed", {31'b0, changed}, 32'h0);
        checkOutput("same_value_device_values", device_values, 32'h0F0F0F0F);

        for (int h = 0; h < 2; h++) applyStimulus(32'h0, 1'b0);
        for (int h = 0; h <= 4; h++) applyStimulus(32'hFFFFFFFF, 1'b0);
        checkOutput("pre_reset_device_values", device_values, 32'h0F0F0F0F);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_device_values", device_values, 32'h0);
        checkOutput("async_reset_changed", {31'b0, changed}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            applyStimulus(32'hFFFFFFFF, 1'b0);
            checkOutput("post_reset_device_values", device_values, (j == 6) ? 32'hFFFFFFFF : 32'h0);
        end
        checkOutput("post_reset_changed", {31'b0, changed}, 32'h1);
        pinModel(32'hFFFFFFFF, 1'b1);

        applyStimulus(32'hFFFFFFFF, 1'b1);
        applyStimulus(32'hFFFFFFFF, 1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
